// File: rtl/mux_scan_sequencer_pkg.sv
// mux_scan_sequencer_pkg: shared FSM state encodings and address width for the mux scan sequencer
package mux_scan_sequencer_pkg;
  localparam int ADDR_W = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/mux_scan_sequencer_settle.sv
// settle_timer: 4-bit settle counter (clk, reset, clear, tick in; expired out when count==SETTLE-1)
module settle_timer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);
  logic [3:0] count;
  always_ff @(posedge clk)
    if (reset || clear) count <= '0;
    else if (tick) count <= count + 4'd1;
  assign expired = count == 4'(SETTLE - 1);
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: scans a 4-bit word through a 4:1 mux (load/data in, address0/1+in0..3 out, mux_out in, serial/word/busy/done out)
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] data,
  output logic       address0,
  output logic       address1,
  output logic       in0,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       mux_out,
  output logic       serial_out,
  output logic       serial_valid,
  output logic [3:0] word_out,
  output logic       busy,
  output logic       done
);
  state_t state;
  logic [ADDR_W-1:0] addr;
  logic [3:0] ins;
  logic expired;
  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk(clk),
    .reset(reset),
    .clear(state == IDLE || expired),
    .tick(state == WAIT),
    .expired(expired)
  );
  assign {address1, address0} = addr;
  assign {in3, in2, in1, in0} = ins;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      ins <= '0;
      serial_out <= 1'b0;
      serial_valid <= 1'b0;
      word_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      serial_valid <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE:
          if (load) begin
            ins <= data;
            addr <= '0;
            word_out <= '0;
            busy <= 1'b1;
            state <= WAIT;
          end
        WAIT:
          if (expired) begin
            serial_out <= mux_out;
            serial_valid <= 1'b1;
            word_out[addr] <= mux_out;
            if (addr == 2'd3) begin
              state <= DONE;
              done <= 1'b1;
            end else addr <= addr + 2'd1;
          end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
